// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble instruction, default reset PC and the
// fetch-stage state encoding.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_RUN      = 2'd0,
    FETCH_HELD     = 2'd1,
    FETCH_REDIRECT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load a new instruction, flush to a bubble, or hold.
module if_id_register
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTRUCTION
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // A flush keeps the PC fields so ID still sees the last fetched address.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (load_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end else if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32IM IF stage: PC and fetch FSM, instruction-memory handshake and the
// IF/ID register, with hold buffering and branch redirect.
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = NOP_INSTRUCTION
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HOLD,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        VALID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_q, buf_d;
  logic         completion;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;

  assign IMEM_READ  = ~RESET & (state_q != FETCH_HELD);
  assign IMEM_ADDR  = req_addr_q;
  assign completion = IMEM_READ & ~IMEM_BUSYWAIT;

  // Redirect outranks hold, which outranks a completing fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = IMEM_READDATA;
    if (BRANCH_TAKEN) begin
      ifid_flush = 1'b1;
      pc_d       = word_align(BRANCH_TARGET);
      state_d    = IMEM_BUSYWAIT ? FETCH_REDIRECT : FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (HOLD) begin
            if (completion) begin
              buf_d   = IMEM_READDATA;
              state_d = FETCH_HELD;
            end
          end else if (completion) begin
            ifid_load = 1'b1;
            pc_d      = pc_q + 32'd4;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        FETCH_HELD: begin
          if (!HOLD) begin
            ifid_load  = 1'b1;
            ifid_instr = buf_q;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH_RUN;
          end
        end
        FETCH_REDIRECT: begin
          if (completion) begin
            state_d = FETCH_RUN;
          end
        end
        default: state_d = FETCH_RUN;
      endcase
    end
    // The bus address may only move once the memory is no longer busy.
    req_addr_d = IMEM_BUSYWAIT ? req_addr_q : pc_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
    end
  end

  if_id_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk_i     (CLK),
    .reset_i   (RESET),
    .load_i    (ifid_load),
    .flush_i   (ifid_flush),
    .instr_i   (ifid_instr),
    .pc_i      (pc_q),
    .pc_plus4_i(pc_q + 32'd4),
    .instr_o   (INSTRUCTION),
    .pc_o      (PC),
    .pc_plus4_o(PC_PLUS_4),
    .valid_o   (VALID)
  );

endmodule
